fifo_rd_stream: RTL and testbench

//   Read-side drain stage for the dual-clock FIFO, in the rclk domain. Pops words through the

---
 rtl/fifo_rd_stream.sv | 103 ++++++++++
 tb/tb_fifo_rd_stream.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the dual-clock FIFO (rclk domain).
// Pops the FIFO through rinc/rempty/rdata and drives a valid/ready stream.
//
// Ports:
//   rclk, rrst_n      read clock, async active-low reset
//   rdata, rempty     show-ahead FIFO head word and empty flag
//   rinc              FIFO pop strobe
//   m_valid, m_data   output stream word, oldest buffered entry
//   m_ready           downstream accept
//   flush             synchronous discard of buffered words
//   occ               buffer occupancy (0..2)
//   xfer_cnt          completed output transfers, wraps
module fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    input  logic             flush,
    output logic [1:0]       occ,
    output logic [CNTW-1:0]  xfer_cnt
);

    logic [1:0]       occ_q, occ_d;
    logic [DSIZE-1:0] b0_q, b0_d;
    logic [DSIZE-1:0] b1_q, b1_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             push;
    logic             pop;

    // The pop strobe only looks at registered occupancy, never at
    // m_ready; the second buffer entry absorbs the one word that may
    // arrive while downstream stalls.
    assign rinc    = rrst_n & ~rempty & ~flush & (occ_q != 2'd2);
    assign m_valid = (occ_q != 2'd0) & ~flush;
    assign m_data  = b0_q;
    assign occ     = occ_q;
    assign xfer_cnt = cnt_q;

    assign push = rinc;
    assign pop  = m_valid & m_ready;

    always_comb begin
        occ_d = occ_q;
        b0_d  = b0_q;
        b1_d  = b1_q;
        cnt_d = pop ? cnt_q + CNTW'(1) : cnt_q;
        if (flush) begin
            // Buffered words are abandoned; entries keep stale data
            // but are never presented because occ returns to 0.
            occ_d = 2'd0;
        end else begin
            unique case (occ_q)
                2'd0: begin
                    if (push) begin
                        occ_d = 2'd1;
                        b0_d  = rdata;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        b0_d = rdata;
                    end else if (push) begin
                        occ_d = 2'd2;
                        b1_d  = rdata;
                    end else if (pop) begin
                        occ_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        occ_d = 2'd1;
                        b0_d  = b1_q;
                    end
                end
                default: begin
                    occ_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ_q <= 2'd0;
            b0_q  <= '0;
            b1_q  <= '0;
            cnt_q <= '0;
        end else begin
            occ_q <= occ_d;
            b0_q  <= b0_d;
            b1_q  <= b1_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO model, scoreboard queue and a
// monitor that checks every transfer the DUT presents.
module tb_fifo_rd_stream;

    localparam int DSIZE = 8;
    localparam int CNTW  = 4;

    logic             rclk = 1'b0;
    logic             rrst_n = 1'b1;
    logic [DSIZE-1:0] rdata = '0;
    logic             rempty = 1'b1;
    logic             rinc;
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_ready = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       occ;
    logic [CNTW-1:0]  xfer_cnt;

    int n_chk = 0;
    int n_fail = 0;

    logic [DSIZE-1:0] fifo_q[$];
    logic [DSIZE-1:0] exp_q[$];
    logic             rinc_s = 1'b0;

    logic             mon_hold = 1'b0;
    logic [DSIZE-1:0] mon_hd = '0;
    logic [CNTW-1:0]  cnt_m = '0;
    logic [DSIZE-1:0] mon_e;

    always #5 rclk = ~rclk;

    fifo_rd_stream #(
        .DSIZE(DSIZE),
        .CNTW (CNTW)
    ) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .rdata   (rdata),
        .rempty  (rempty),
        .rinc    (rinc),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .flush   (flush),
        .occ     (occ),
        .xfer_cnt(xfer_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic fifo_outs();
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? '0 : fifo_q[0];
    endtask

    task automatic put(input logic [DSIZE-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_outs();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 5000) begin
            @(negedge rclk);
            #3;
            n++;
        end
        chk({name, "_drain"},
            32'((exp_q.size() == 0) && (fifo_q.size() == 0)), 32'd1);
        @(negedge rclk);
        #3;
    endtask

    // FIFO model: the head word is consumed at the edge where rinc was
    // high; rinc_s is the value sampled between edges by the monitor.
    initial begin
        forever begin
            @(posedge rclk);
            #1;
            if (rinc_s) begin
                if (fifo_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL fifo_pop: rinc with empty FIFO @%0t",
                             $time);
                end else begin
                    void'(fifo_q.pop_front());
                end
            end
            fifo_outs();
        end
    end

    // Monitor: samples mid-cycle, predicts the transfer at the next edge.
    initial begin
        forever begin
            @(negedge rclk);
            #2;
            rinc_s = rinc;
            if (!rrst_n) begin
                cnt_m    = '0;
                mon_hold = 1'b0;
            end else begin
                chk("xfer_cnt", 32'(xfer_cnt), 32'(cnt_m));
                chk("occ_le_2", 32'(occ <= 2'd2), 32'd1);
                chk("rinc_while_empty", 32'(rinc & rempty), 32'd0);
                if (mon_hold && !flush) begin
                    chk("hold_valid", 32'(m_valid), 32'd1);
                    chk("hold_data", 32'(m_data), 32'(mon_hd));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL extra_word: got %0h expected none",
                                 m_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("m_data", 32'(m_data), 32'(mon_e));
                    end
                    cnt_m = cnt_m + CNTW'(1);
                end
                mon_hold = m_valid & ~m_ready;
                mon_hd   = m_data;
            end
        end
    end

    initial begin
        // Reset state
        #1 rrst_n = 1'b0;
        #1;
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_cnt", 32'(xfer_cnt), 32'd0);
        chk("rst_rinc", 32'(rinc), 32'd0);
        @(posedge rclk);
        #2 rrst_n = 1'b1;

        // 1: streaming A0..A7 at full rate
        @(negedge rclk);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) put(8'hA0 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge rclk);
            #3;
            chk("s1_rinc", 32'(rinc), 32'(i < 8));
            chk("s1_occ", 32'(occ), (i == 0 || i == 9) ? 32'd0 : 32'd1);
            if (i >= 1 && i <= 8)
                chk("s1_data", 32'(m_data), 32'(8'hA0 + 8'(i - 1)));
        end
        chk("s1_cnt", 32'(xfer_cnt), 32'd8);

        // 2: backpressure with 5 words
        @(negedge rclk);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) put(8'hB0 + 8'(i));
        repeat (4) @(negedge rclk);
        #3;
        chk("s2_occ", 32'(occ), 32'd2);
        chk("s2_rinc", 32'(rinc), 32'd0);
        chk("s2_valid", 32'(m_valid), 32'd1);
        chk("s2_data", 32'(m_data), 32'hB0);
        chk("s2_fifo_left", 32'(fifo_q.size()), 32'd3);
        @(negedge rclk);
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge rclk);
            #3;
            chk("s2_nogap", 32'(m_valid), 32'(i < 5));
            if (i < 5) chk("s2_order", 32'(m_data), 32'(8'hB0 + 8'(i)));
        end
        chk("s2_cnt", 32'(xfer_cnt), 32'd13);

        // 4: flush with occ=2 and 3 words left in the FIFO
        @(negedge rclk);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) put(8'hC0 + 8'(i));
        repeat (4) @(negedge rclk);
        #3;
        chk("f_occ_pre", 32'(occ), 32'd2);
        @(negedge rclk);
        flush = 1'b1;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        #3;
        chk("f_valid", 32'(m_valid), 32'd0);
        chk("f_rinc", 32'(rinc), 32'd0);
        @(negedge rclk);
        flush = 1'b0;
        #3;
        chk("f_occ_post", 32'(occ), 32'd0);
        chk("f_cnt", 32'(xfer_cnt), 32'd13);
        @(negedge rclk);
        m_ready = 1'b1;
        #3;
        chk("f_next_valid", 32'(m_valid), 32'd1);
        chk("f_next_data", 32'(m_data), 32'hC2);
        drain("flush");
        chk("f_cnt_wrap", 32'(xfer_cnt), 32'd0);

        // 3: random fill and random m_ready over 10k words
        for (int sent = 0; sent < 10000;) begin
            @(negedge rclk);
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                put(8'($urandom()));
                sent++;
            end
        end
        @(negedge rclk);
        m_ready = 1'b1;
        drain("random");
        chk("r_cnt", 32'(xfer_cnt), 32'd0);

        // 5: async reset with occ=2, then counter wrap over 17 words
        @(negedge rclk);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) put(8'hD0 + 8'(i));
        repeat (4) @(negedge rclk);
        #3;
        chk("r_occ_pre", 32'(occ), 32'd2);
        @(posedge rclk);
        #2 rrst_n = 1'b0;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        #1;
        chk("ar_occ", 32'(occ), 32'd0);
        chk("ar_valid", 32'(m_valid), 32'd0);
        chk("ar_rinc", 32'(rinc), 32'd0);
        chk("ar_cnt", 32'(xfer_cnt), 32'd0);
        chk("ar_fifo_kept", 32'(fifo_q.size()), 32'd3);
        @(posedge rclk);
        #2 rrst_n = 1'b1;
        @(negedge rclk);
        m_ready = 1'b1;
        for (int i = 0; i < 14; i++) put(8'hE0 + 8'(i));
        for (int i = 0; i < 19; i++) begin
            if (i > 0) @(negedge rclk);
            #3;
            if (i == 16) chk("w_cnt15", 32'(xfer_cnt), 32'd15);
            if (i == 17) chk("w_cnt0", 32'(xfer_cnt), 32'd0);
            if (i == 18) chk("w_cnt1", 32'(xfer_cnt), 32'd1);
        end
        drain("wrap");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
